// File: rtl/io_responder_pkg.sv
// ----------------------------------------------------------------------------
// io_responder_pkg
//   Shared widths, the default FIFO depth and the job-control FSM state
//   encoding for the io_responder block and its FIFO sub-module.
// ----------------------------------------------------------------------------
package io_responder_pkg;

    localparam int DEPTH_DEF = 8;          // entries per FIFO
    localparam int VI_W      = 16;         // operand vi width
    localparam int UI_W      = 2;          // operand ui width
    localparam int IN_W      = VI_W + UI_W; // input FIFO entry {vi, ui}
    localparam int WD_W      = 21;         // engine result width
    localparam int JOBS_W    = 8;          // completed-job counter width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } state_t;

endpackage

// File: rtl/io_responder_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO.
//   Ports:
//     clock, reset : clock and synchronous active-high reset
//     push, din    : write strobe and data
//     pop          : read strobe; ignored while empty
//     dout         : current head entry (combinational)
//     full, empty  : occupancy status
//     count        : occupancy, 0..DEPTH
//   A push while full is accepted only when a real pop happens in the same
//   cycle (the slot being freed is reused); otherwise it is dropped.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are unreachable until written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/io_responder.sv
// ----------------------------------------------------------------------------
// io_responder
//   Bridges a host and a compute engine. The host loads {vi, ui} operand
//   pairs into an input FIFO; the engine pulls them with rd_req, pushes
//   results with wr_req into a result FIFO the host drains with out_pop.
//   A small FSM launches a job (one-cycle start) whenever operands are
//   waiting and counts jobs the engine reports done.
//   Ports:
//     clock, reset            : clock, synchronous active-high reset
//     ld_en, ld_vi, ld_ui     : host push into input FIFO
//     rd_req -> vi, ui        : engine operand fetch, registered (latency 1)
//     wr_req, wr_data         : engine result push
//     done                    : engine job-complete level
//     start                   : one-cycle job-launch pulse
//     out_pop, out_data,
//     out_valid               : host result drain (first-word-fall-through)
//     in_count, out_count     : FIFO occupancies
//     underflow, overflow     : sticky error flags, cleared only by reset
//     jobs                    : completed-job counter (wraps)
// ----------------------------------------------------------------------------
module io_responder
    import io_responder_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ld_en,
    input  logic [VI_W-1:0]          ld_vi,
    input  logic [UI_W-1:0]          ld_ui,
    input  logic                     rd_req,
    output logic [VI_W-1:0]          vi,
    output logic [UI_W-1:0]          ui,
    input  logic                     wr_req,
    input  logic [WD_W-1:0]          wr_data,
    input  logic                     done,
    output logic                     start,
    input  logic                     out_pop,
    output logic [WD_W-1:0]          out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     underflow,
    output logic                     overflow,
    output logic [JOBS_W-1:0]        jobs
);

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic [IN_W-1:0] in_dout;
    logic            in_full;
    logic            in_empty;
    logic            out_full;
    logic            out_empty;

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clock (clock),
        .reset (reset),
        .push  (ld_en),
        .pop   (rd_req),
        .din   ({ld_vi, ld_ui}),
        .dout  (in_dout),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    sync_fifo #(
        .WIDTH (WD_W),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_req),
        .pop   (out_pop),
        .din   (wr_data),
        .dout  (out_data),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    assign out_valid = !out_empty;

    // ------------------------------------------------------------------
    // Operand serving and error flags
    // ------------------------------------------------------------------
    logic in_serve;
    logic in_under;
    logic in_drop;
    logic out_drop;

    assign in_serve = rd_req && !in_empty;
    assign in_under = rd_req && in_empty;
    // A full FIFO is never empty, so a same-cycle pop always frees a slot.
    assign in_drop  = ld_en && in_full && !rd_req;
    assign out_drop = wr_req && out_full && !out_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            vi        <= '0;
            ui        <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_serve) {vi, ui} <= in_dout;
            if (in_under) underflow <= 1'b1;
            if (in_drop || out_drop) overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Job-control FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   job_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            jobs    <= '0;
        end else begin
            state_q <= state_d;
            if (job_done) jobs <= jobs + JOBS_W'(1);
        end
    end

    // done is only looked at in BUSY, so a stray done in IDLE or LAUNCH
    // (including one arriving after a reset aborted a job) is ignored.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        job_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AUTO_START && !in_empty) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                start   = 1'b1;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (done) begin
                    state_d  = ST_IDLE;
                    job_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;
    import io_responder_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              ld_en;
    logic [VI_W-1:0]   ld_vi;
    logic [UI_W-1:0]   ld_ui;
    logic              rd_req;
    logic [VI_W-1:0]   vi;
    logic [UI_W-1:0]   ui;
    logic              wr_req;
    logic [WD_W-1:0]   wr_data;
    logic              done;
    logic              start;
    logic              out_pop;
    logic [WD_W-1:0]   out_data;
    logic              out_valid;
    logic [CW-1:0]     in_count;
    logic [CW-1:0]     out_count;
    logic              underflow;
    logic              overflow;
    logic [JOBS_W-1:0] jobs;

    int errors = 0;
    int checks = 0;

    logic [IN_W-1:0] in_q  [$];
    logic [WD_W-1:0] out_q [$];

    always #5 clock = ~clock;

    io_responder #(.DEPTH(DEPTH), .AUTO_START(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .ld_en     (ld_en),
        .ld_vi     (ld_vi),
        .ld_ui     (ld_ui),
        .rd_req    (rd_req),
        .vi        (vi),
        .ui        (ui),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .done      (done),
        .start     (start),
        .out_pop   (out_pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .in_count  (in_count),
        .out_count (out_count),
        .underflow (underflow),
        .overflow  (overflow),
        .jobs      (jobs)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        ld_en = 0; ld_vi = '0; ld_ui = '0; rd_req = 0;
        wr_req = 0; wr_data = '0; done = 0; out_pop = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        in_q.delete();
        out_q.delete();
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (in_count !== 0)  begin errors++; $display("FAIL reset_in_count got=%0d exp=0", in_count); end
        checks++; if (out_count !== 0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        checks++; if (out_valid !== 0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (vi !== 0)        begin errors++; $display("FAIL reset_vi got=%h exp=0", vi); end
        checks++; if (ui !== 0)        begin errors++; $display("FAIL reset_ui got=%h exp=0", ui); end
        checks++; if (start !== 0)     begin errors++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if (underflow !== 0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (overflow !== 0)  begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (jobs !== 0)      begin errors++; $display("FAIL reset_jobs got=%0d exp=0", jobs); end
    endtask

    task automatic test_load_serve;
        logic [IN_W-1:0] e;
        do_reset();
        ld_en = 1; ld_vi = 16'h1234; ld_ui = 2'b10;
        in_q.push_back({16'h1234, 2'b10});
        tick();
        ld_en = 0;
        checks++; if (in_count !== 1) begin errors++; $display("FAIL load_in_count got=%0d exp=1", in_count); end
        rd_req = 1;
        checks++; if (vi !== 16'h0000) begin errors++; $display("FAIL serve_latency got=%h exp=0000", vi); end
        tick();
        rd_req = 0;
        e = in_q.pop_front();
        checks++; if ({vi, ui} !== e) begin errors++; $display("FAIL serve_data got=%h exp=%h", {vi, ui}, e); end
        checks++; if (in_count !== 0) begin errors++; $display("FAIL serve_in_count got=%0d exp=0", in_count); end
        tick();
        checks++; if ({vi, ui} !== e) begin errors++; $display("FAIL serve_hold got=%h exp=%h", {vi, ui}, e); end
    endtask

    task automatic test_in_overflow;
        logic [IN_W-1:0] e;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            ld_en = 1; ld_vi = 16'(16'h0100 + i); ld_ui = 2'(i);
            if (in_q.size() < DEPTH) in_q.push_back({ld_vi, ld_ui});
            tick();
        end
        ld_en = 0;
        checks++; if (in_count !== 4'(DEPTH)) begin errors++; $display("FAIL ovf_in_count got=%0d exp=%0d", in_count, DEPTH); end
        checks++; if (overflow !== 1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (underflow !== 0) begin errors++; $display("FAIL ovf_underflow got=%b exp=0", underflow); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_req = 1;
            tick();
            rd_req = 0;
            e = in_q.pop_front();
            checks++; if ({vi, ui} !== e) begin errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, {vi, ui}, e); end
        end
        rd_req = 1;
        tick();
        rd_req = 0;
        checks++; if (vi !== 16'h0107) begin errors++; $display("FAIL ovf_ninth_not_served got=%h exp=0107", vi); end
        checks++; if (underflow !== 1) begin errors++; $display("FAIL ovf_then_underflow got=%b exp=1", underflow); end
    endtask

    task automatic test_underflow;
        logic [IN_W-1:0] e;
        do_reset();
        ld_en = 1; ld_vi = 16'hABCD; ld_ui = 2'b01;
        in_q.push_back({16'hABCD, 2'b01});
        tick();
        ld_en = 0; rd_req = 1;
        tick();
        rd_req = 0;
        e = in_q.pop_front();
        checks++; if ({vi, ui} !== e) begin errors++; $display("FAIL udf_first got=%h exp=%h", {vi, ui}, e); end
        checks++; if (underflow !== 0) begin errors++; $display("FAIL udf_early got=%b exp=0", underflow); end
        rd_req = 1;
        tick();
        rd_req = 0;
        checks++; if ({vi, ui} !== e) begin errors++; $display("FAIL udf_hold got=%h exp=%h", {vi, ui}, e); end
        checks++; if (underflow !== 1) begin errors++; $display("FAIL udf_flag got=%b exp=1", underflow); end
        checks++; if (in_count !== 0) begin errors++; $display("FAIL udf_in_count got=%0d exp=0", in_count); end
        // simultaneous push and pop on an empty FIFO
        do_reset();
        ld_en = 1; ld_vi = 16'h5A5A; ld_ui = 2'b11; rd_req = 1;
        in_q.push_back({16'h5A5A, 2'b11});
        tick();
        ld_en = 0; rd_req = 0;
        checks++; if (underflow !== 1) begin errors++; $display("FAIL sim_underflow got=%b exp=1", underflow); end
        checks++; if (in_count !== 1) begin errors++; $display("FAIL sim_in_count got=%0d exp=1", in_count); end
        checks++; if (vi !== 16'h0000) begin errors++; $display("FAIL sim_vi_hold got=%h exp=0000", vi); end
        rd_req = 1;
        tick();
        rd_req = 0;
        e = in_q.pop_front();
        checks++; if ({vi, ui} !== e) begin errors++; $display("FAIL sim_stored got=%h exp=%h", {vi, ui}, e); end
    endtask

    task automatic test_fsm;
        int n;
        int saw;
        do_reset();
        ld_en = 1; ld_vi = 16'h0042; ld_ui = 2'b00;
        tick();
        ld_en = 0;
        n = 0;
        while (start !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (n !== 1) begin errors++; $display("FAIL fsm_start_latency got=%0d exp=1", n); end
        rd_req = 1;   // engine consumes the operand
        tick();
        rd_req = 0;
        checks++; if (start !== 0) begin errors++; $display("FAIL fsm_start_one_cycle got=%b exp=0", start); end
        repeat (3) tick();
        done = 1;
        tick();
        done = 0;
        checks++; if (jobs !== 1) begin errors++; $display("FAIL fsm_jobs got=%0d exp=1", jobs); end
        saw = 0;
        repeat (3) begin tick(); if (start) saw++; end
        checks++; if (saw !== 0) begin errors++; $display("FAIL fsm_idle_no_start got=%0d exp=0", saw); end
        done = 1;
        tick();
        done = 0;
        tick();
        checks++; if (jobs !== 1) begin errors++; $display("FAIL fsm_done_in_idle got=%0d exp=1", jobs); end
    endtask

    task automatic test_jobs_wrap;
        int starts;
        int consec;
        int n;
        bit prev;
        bit seen255;
        bit checked_launch;
        do_reset();
        done = 1;                 // engine reports done continuously
        ld_en = 1; ld_vi = 16'h0001;
        tick();
        ld_en = 0;
        starts = 0; consec = 0; n = 0; prev = 0; seen255 = 0; checked_launch = 0;
        while (!(seen255 && jobs === 0) && n < 2000) begin
            tick();
            n++;
            if (start) starts++;
            if (start && prev) consec++;
            prev = start;
            if (jobs === 8'd255) seen255 = 1;
            if (starts == 1 && !start && !checked_launch) begin
                checked_launch = 1;
                checks++; if (jobs !== 0) begin errors++; $display("FAIL wrap_done_in_launch got=%0d exp=0", jobs); end
            end
        end
        done = 0;
        checks++; if (!(seen255 && jobs === 0)) begin errors++; $display("FAIL wrap_timeout got jobs=%0d exp=0 after 255", jobs); end
        checks++; if (starts !== 256) begin errors++; $display("FAIL wrap_start_count got=%0d exp=256", starts); end
        checks++; if (consec !== 0) begin errors++; $display("FAIL wrap_consecutive_start got=%0d exp=0", consec); end
    endtask

    task automatic test_reset_midjob;
        int n;
        int saw;
        do_reset();
        ld_en = 1; ld_vi = 16'h0777;
        tick();
        ld_en = 0;
        n = 0;
        while (start !== 1'b1 && n < 10) begin tick(); n++; end
        tick();                   // BUSY
        reset = 1; ld_en = 1; wr_req = 1; wr_data = 21'h00BEEF;
        tick();
        reset = 0; ld_en = 0; wr_req = 0;
        checks++; if (in_count !== 0)  begin errors++; $display("FAIL rst_mid_in_count got=%0d exp=0", in_count); end
        checks++; if (out_count !== 0) begin errors++; $display("FAIL rst_mid_out_count got=%0d exp=0", out_count); end
        checks++; if (start !== 0)     begin errors++; $display("FAIL rst_mid_start got=%b exp=0", start); end
        done = 1;
        tick();
        done = 0;
        saw = 0;
        repeat (3) begin tick(); if (start) saw++; end
        checks++; if (jobs !== 0) begin errors++; $display("FAIL rst_mid_jobs got=%0d exp=0", jobs); end
        checks++; if (saw !== 0)  begin errors++; $display("FAIL rst_mid_relaunch got=%0d exp=0", saw); end
    endtask

    task automatic test_result;
        do_reset();
        wr_req = 1; wr_data = 21'h1FFFFF; out_q.push_back(21'h1FFFFF);
        tick();
        wr_data = 21'h000001; out_q.push_back(21'h000001);
        tick();
        wr_req = 0;
        checks++; if (out_valid !== 1)       begin errors++; $display("FAIL res_valid got=%b exp=1", out_valid); end
        checks++; if (out_count !== 2)       begin errors++; $display("FAIL res_count got=%0d exp=2", out_count); end
        checks++; if (out_data !== out_q[0]) begin errors++; $display("FAIL res_head0 got=%h exp=%h", out_data, out_q[0]); end
        out_pop = 1;
        tick();
        out_pop = 0;
        void'(out_q.pop_front());
        checks++; if (out_data !== out_q[0]) begin errors++; $display("FAIL res_head1 got=%h exp=%h", out_data, out_q[0]); end
        out_pop = 1;
        tick();
        out_pop = 0;
        void'(out_q.pop_front());
        checks++; if (out_valid !== 0) begin errors++; $display("FAIL res_empty got=%b exp=0", out_valid); end
        out_pop = 1;              // pop while empty is harmless
        tick();
        out_pop = 0;
        checks++; if (out_count !== 0) begin errors++; $display("FAIL res_pop_empty_count got=%0d exp=0", out_count); end
        checks++; if (underflow !== 0 || overflow !== 0) begin errors++; $display("FAIL res_pop_empty_flags got=%b%b exp=00", underflow, overflow); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr_req = 1; wr_data = 21'(i * 3 + 7);
            out_q.push_back(wr_data);
            tick();
        end
        wr_req = 0;
        checks++; if (out_count !== 4'(DEPTH)) begin errors++; $display("FAIL b2b_full got=%0d exp=%0d", out_count, DEPTH); end
        wr_req = 1; out_pop = 1; wr_data = 21'h0ABCDE;
        tick();
        wr_req = 0; out_pop = 0;
        void'(out_q.pop_front());
        out_q.push_back(21'h0ABCDE);
        checks++; if (overflow !== 0) begin errors++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
        checks++; if (out_count !== 4'(DEPTH)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", out_count, DEPTH); end
        wr_req = 1; wr_data = 21'h155555;
        tick();
        wr_req = 0;
        checks++; if (overflow !== 1) begin errors++; $display("FAIL b2b_drop_flag got=%b exp=1", overflow); end
        checks++; if (out_count !== 4'(DEPTH)) begin errors++; $display("FAIL b2b_drop_count got=%0d exp=%0d", out_count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_data !== out_q[0]) begin errors++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, out_data, out_q[0]); end
            out_pop = 1;
            tick();
            out_pop = 0;
            void'(out_q.pop_front());
        end
        checks++; if (out_valid !== 0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_serve();
        test_in_overflow();
        test_underflow();
        test_fsm();
        test_jobs_wrap();
        test_reset_midjob();
        test_result();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO; power of two, minimum 2.
REQ-002 Parameter AUTO_START, default 1, 1 enables automatic job launch.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-005 ld_en  input  1  host push strobe into input FIFO.
REQ-006 ld_vi  input  16  host vi word pushed with ld_en.
REQ-007 ld_ui  input  2  host ui word pushed with ld_en.
REQ-008 rd_req  input  1  engine request for next operand pair.
REQ-009 vi  output  16  operand word served to engine.
REQ-010 ui  output  2  operand word served to engine.
REQ-011 wr_req  input  1  engine result strobe.
REQ-012 wr_data  input  21  engine result word.
REQ-013 done  input  1  engine job-complete level.
REQ-014 start  output  1  one-cycle job-launch pulse to engine.
REQ-015 out_pop  input  1  host pop strobe from result FIFO.
REQ-016 out_data  output  21  result FIFO head, valid when out_valid.
REQ-017 out_valid  output  1  result FIFO non-empty.
REQ-018 in_count, out_count  output  log2(DEPTH)+1 each  FIFO occupancies.
REQ-019 underflow, overflow  output  1 each  sticky error flags.
REQ-020 jobs  output  8  completed-job counter.

Function
REQ-021 Input FIFO push on ld_en; when full, push accepted only if rd_req pops the same cycle; otherwise data dropped and overflow set.
REQ-022 rd_req with input FIFO non-empty: head popped; vi/ui registered with head value, visible the cycle after rd_req (latency 1); held until next accepted rd_req.
REQ-023 rd_req with input FIFO empty: vi/ui hold previous value, underflow set, no pointer change.
REQ-024 Simultaneous ld_en and rd_req on empty FIFO: the pop is an underflow; the push is stored.
REQ-025 Result FIFO push on wr_req with wr_data; when full, push accepted only if out_pop pops the same cycle; otherwise dropped and overflow set.
REQ-026 out_data is combinational read of result head (first-word-fall-through); out_pop with out_valid low is ignored without error.
REQ-027 Pointers wrap modulo DEPTH; counts range 0..DEPTH exactly.
REQ-028 FSM states IDLE, LAUNCH, BUSY.
REQ-029 IDLE -> LAUNCH when AUTO_START=1 and in_count != 0; otherwise stay.
REQ-030 LAUNCH: start=1 for exactly that cycle; next state BUSY unconditionally.
REQ-031 BUSY -> IDLE on done=1; jobs increments by 1 on that transition, wrapping 255 -> 0.
REQ-032 done=1 in IDLE or LAUNCH is ignored.
REQ-033 start asserted only in LAUNCH; never two consecutive cycles.

Reset
REQ-034 On reset: both FIFOs empty (pointers 0), in_count=out_count=0, out_valid=0, vi=0, ui=0, start=0, underflow=overflow=0, jobs=0, state IDLE.
REQ-035 Reset mid-job (LAUNCH or BUSY) aborts to IDLE; subsequent done pulse from the engine is ignored in IDLE; stored data is discarded.
REQ-036 Reset dominates all other inputs in the same cycle.
REQ-037 Sticky flags clear only by reset.

Structure
REQ-038 Shared package holds DEPTH default, VI_W=16, UI_W=2, WD_W=21, and the FSM state enum.
REQ-039 One sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated twice: WIDTH=18 for input and WIDTH=21 for result.

Verification
REQ-040 Reset, push (vi=16'h1234, ui=2'b10), then rd_req -> vi=16'h1234, ui=2'b10 one cycle later; in_count 1->0.
REQ-041 Push 9 words with DEPTH=8 and no pops -> in_count=8, overflow=1, the 9th word is never served.
REQ-042 rd_req on an empty FIFO after serving 16'hABCD -> vi stays 16'hABCD, underflow=1.
REQ-043 One word loaded -> start pulses one cycle; done pulsed 5 cycles later -> state IDLE, jobs=1; an extra done in IDLE leaves jobs=1.
REQ-044 wr_req with 21'h1FFFFF then 21'h000001 -> out_data=21'h1FFFFF with out_valid=1; out_pop -> out_data=21'h000001; second out_pop -> out_valid=0.
REQ-045 Full result FIFO with wr_req and out_pop in the same cycle -> write accepted, overflow stays 0, out_count stays 8.
